// File: rtl/if_ctrl_pkg.sv
// Shared encodings for the instruction-fetch controller: FSM states,
// reset/chip-enable levels and the pipeline stall vector patterns.
package if_ctrl_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } if_state_e;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Stall vector bit order is {wb, mem, ex, id, if, pc}
    localparam logic [5:0] STALL_NONE   = 6'b000000;
    localparam logic [5:0] STALL_IFWAIT = 6'b000011;
    localparam logic [5:0] STALL_ID     = 6'b000111;
    localparam logic [5:0] STALL_EX     = 6'b001111;

endpackage

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: owns the PC, handshakes with the instruction
// ROM, merges stall/branch/flush requests into the stall vector and next PC.
module if_ctrl
    import if_ctrl_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
    parameter int                 STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               rom_ready,
    output logic               rom_ce,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               inst_valid,
    output logic [STALL_W-1:0] stall
);

    if_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pending_vld_q, pending_vld_d;
    logic [ADDR_W-1:0]  pending_tgt_q, pending_tgt_d;
    logic [STALL_W-1:0] stall_s;
    logic               inst_valid_s;
    logic               branch_acc_s;
    logic [ADDR_W-1:0]  pc_inc_s;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Stall priority encoder: flush overrides everything, then EX, ID, ROM wait
    always_comb begin
        stall_s = STALL_NONE;
        if (flush) begin
            stall_s = STALL_NONE;
        end else if (stallreq_ex) begin
            stall_s = STALL_EX;
        end else if (stallreq_id) begin
            stall_s = STALL_ID;
        end else if ((state_q == S_FETCH) && !rom_ready) begin
            stall_s = STALL_IFWAIT;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    assign inst_valid_s = (state_q == S_FETCH) & rom_ready & ~flush & ~stallreq_id & ~stallreq_ex;
    assign branch_acc_s = branch_flag_i & ~stall_s[2] & ~flush;
    assign pc_inc_s     = pc_q + ADDR_W'(32'd4);

    // Next-PC mux; a branch seen during a ROM wait is parked until the
    // delay-slot word is actually captured
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_vld_d = pending_vld_q;
        pending_tgt_d = pending_tgt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (flush) begin
                    pc_d = align_addr(new_pc);
                end else begin
                    pc_d = pc_q;
                end
            end
            S_FETCH: begin
                if (flush) begin
                    pc_d          = align_addr(new_pc);
                    pending_vld_d = 1'b0;
                end else if (inst_valid_s) begin
                    if (pending_vld_q) begin
                        pc_d = pending_tgt_q;
                    end else if (branch_acc_s) begin
                        pc_d = align_addr(branch_target_i);
                    end else begin
                        pc_d = pc_inc_s;
                    end
                    pending_vld_d = 1'b0;
                end else if (branch_acc_s) begin
                    pending_vld_d = 1'b1;
                    pending_tgt_d = align_addr(branch_target_i);
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d       = S_IDLE;
                pc_d          = RESET_PC;
                pending_vld_d = 1'b0;
                pending_tgt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and PC registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pending_vld_q <= 1'b0;
            pending_tgt_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_vld_q <= pending_vld_d;
            pending_tgt_q <= pending_tgt_d;
        end
    end

    assign rom_ce     = (state_q == S_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr   = pc_q;
    assign pc         = pc_q;
    assign inst_valid = inst_valid_s;
    assign stall      = stall_s;

endmodule

// File: tb/tb_if_ctrl.sv
// Directed bench for if_ctrl: vectors push expected outputs into a queue,
// an independent monitor pops and compares once per cycle.
module tb_if_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        rom_ready = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] pc;
    logic        inst_valid;
    logic [5:0]  stall;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    typedef struct {
        int          id;
        logic        ce;
        logic [31:0] pc;
        logic        iv;
        logic [5:0]  stall;
    } exp_t;

    exp_t exp_q[$];

    if_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .flush(flush), .new_pc(new_pc), .rom_ready(rom_ready),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .pc(pc),
        .inst_valid(inst_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the edge and queue the expected outputs
    task automatic vec(input logic r, input logic sid, input logic sex,
                       input logic bf, input logic [31:0] bt,
                       input logic fl, input logic [31:0] npc, input logic rdy,
                       input logic e_ce, input logic [31:0] e_pc,
                       input logic e_iv, input logic [5:0] e_st);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = sid; stallreq_ex = sex;
        branch_flag_i = bf; branch_target_i = bt;
        flush = fl; new_pc = npc; rom_ready = rdy;
        vec_no++;
        e.id = vec_no; e.ce = e_ce; e.pc = e_pc; e.iv = e_iv; e.stall = e_st;
        exp_q.push_back(e);
    endtask

    // Monitor: compare everything the DUT presents against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 5;
            if (rom_ce !== e.ce) begin
                errors++;
                $display("FAIL v%0d rom_ce: got %b want %b", e.id, rom_ce, e.ce);
            end
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL v%0d pc: got %h want %h", e.id, pc, e.pc);
            end
            if (rom_addr !== e.pc) begin
                errors++;
                $display("FAIL v%0d rom_addr: got %h want %h", e.id, rom_addr, e.pc);
            end
            if (inst_valid !== e.iv) begin
                errors++;
                $display("FAIL v%0d inst_valid: got %b want %b", e.id, inst_valid, e.iv);
            end
            if (stall !== e.stall) begin
                errors++;
                $display("FAIL v%0d stall: got %b want %b", e.id, stall, e.stall);
            end
        end
    end

    // A branch accepted while one is already parked is illegal stimulus
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.pending_vld_q && branch_flag_i && !stall[2] && !flush))
            else begin
                errors++;
                $display("FAIL pending_overwrite: branch accepted with pending_vld=1");
            end
        end
    end

    initial begin
        //  rst sid sex bf  bt            fl  npc           rdy  ce  pc            iv  stall
        vec(1, 0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 6'b000000);
        vec(1, 0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 6'b000000);
        vec(1, 0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 6'b000000);
        // single idle cycle, rom_ready ignored
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h0,         1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h4,         1, 6'b000000);
        // ROM wait at 8 for two cycles
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h8,         0, 6'b000011);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h8,         0, 6'b000011);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h8,         1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hC,         1, 6'b000000);
        // branch at 0x10 resolved while fetching delay slot 0x14
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h10,        1, 6'b000000);
        vec(0, 0, 0, 1, 32'h100,       0, 32'h0,         1,   1, 32'h14,        1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h100,       1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h104,       1, 6'b000000);
        // branch during ROM wait on the delay slot -> parked target
        vec(0, 0, 0, 1, 32'h200,       0, 32'h0,         0,   1, 32'h108,       0, 6'b000011);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h108,       0, 6'b000011);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h108,       1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h200,       1, 6'b000000);
        // EX and ID stall requests; branch under ID stall is not accepted
        vec(0, 0, 1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h204,       0, 6'b001111);
        vec(0, 1, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h204,       0, 6'b000111);
        vec(0, 1, 0, 1, 32'h300,       0, 32'h0,         1,   1, 32'h204,       0, 6'b000111);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h204,       1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h208,       1, 6'b000000);
        // flush during ROM wait with a parked branch
        vec(0, 0, 0, 1, 32'h400,       0, 32'h0,         0,   1, 32'h20C,       0, 6'b000011);
        vec(0, 0, 0, 0, 32'h0,         1, 32'h80,        0,   1, 32'h20C,       0, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h80,        1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h84,        1, 6'b000000);
        // flush + ready + branch together: word discarded, branch dropped, low bits cleared
        vec(0, 0, 0, 1, 32'h500,       1, 32'h103,       1,   1, 32'h88,        0, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h100,       1, 6'b000000);
        // wrap from the top of the address space
        vec(0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1,   1, 32'h104,       0, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'hFFFF_FFFC, 1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h0,         1, 6'b000000);
        // unaligned branch target is word-aligned
        vec(0, 0, 0, 1, 32'h123,       0, 32'h0,         1,   1, 32'h4,         1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h120,       0, 6'b000011);
        // reset mid-wait, then flush while idle
        vec(1, 0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h120,       0, 6'b000011);
        vec(0, 0, 0, 0, 32'h0,         1, 32'h40,        1,   0, 32'h0,         0, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h40,        1, 6'b000000);
        vec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h44,        0, 6'b000011);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_ctrl.md
Name: if_ctrl

Overview:
Instruction-fetch controller for the OpenMIPS core. It owns the program counter, drives the instruction ROM chip-enable and address, and runs a ready handshake so the ROM may insert wait states. It also merges ID/EX stall requests, ROM wait, branch redirect and exception flush into the 6-bit pipeline stall vector and the next-PC selection, and feeds IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and used for the first fetch
ADDR_W, 32, PC / ROM address width
STALL_W, 6, stall vector width; bit order {wb,mem,ex,id,if,pc} = [5:0]

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous reset, active-high (`RstEnable = 1'b1)
stallreq_id  input  1  ID-stage stall request
stallreq_ex  input  1  EX-stage stall request
branch_flag_i  input  1  ID resolved a taken branch/jump
branch_target_i  input  ADDR_W  branch/jump target
flush  input  1  exception flush from CP0/ctrl
new_pc  input  ADDR_W  exception handler / ERET address
rom_ready  input  1  ROM returns data for rom_addr this cycle
rom_ce  output  1  ROM chip enable (`ChipEnable/`ChipDisable)
rom_addr  output  ADDR_W  fetch address (equals pc)
pc  output  ADDR_W  current fetch PC, to IF/ID
inst_valid  output  1  IF/ID captures the fetched word this cycle
stall  output  STALL_W  pipeline stall vector

Behaviour:
- Reset (rst=1 at posedge): state<=S_IDLE, pc<=RESET_PC, pending_vld<=0, pending_tgt<=0. Outputs: rom_ce=0, stall=0, inst_valid=0.
- States: S_IDLE (rom_ce=0, lasts exactly one cycle after reset deasserts) -> S_FETCH (rom_ce=1, steady state). Reset returns to S_IDLE from any state, mid-wait included; any pending redirect is discarded.
- rom_addr = pc combinationally. rom_ready is ignored in S_IDLE.
- Stall vector (combinational, priority top-down):
  flush=1 -> 6'b000000
  stallreq_ex -> 6'b001111
  stallreq_id -> 6'b000111
  S_FETCH & !rom_ready -> 6'b000011 (IF/ID inserts a bubble)
  else 6'b000000
- inst_valid = S_FETCH & rom_ready & !flush & !stallreq_id & !stallreq_ex. PC advances only on inst_valid; otherwise the same address is refetched.
- Branch accepted when branch_flag_i & !stall[2] & !flush. Delay slot: the word being fetched that cycle is the delay slot, and the target takes effect on the following fetch.
- Next-PC at posedge (S_FETCH, priority):
  1. flush -> pc<=new_pc, pending_vld<=0.
  2. inst_valid -> pc<=pending_vld ? pending_tgt : (branch accepted ? branch_target_i : pc+4); pending_vld<=0.
  3. branch accepted & !inst_valid (ROM wait) -> pending_vld<=1, pending_tgt<=branch_target_i; pc held.
  4. else pc held.
- In S_IDLE, flush loads pc<=new_pc. The transition to S_FETCH still occurs.
- Addresses are written with bits [1:0] forced to 2'b00. pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Branch accepted while pending_vld=1 overwrites pending_tgt. This cannot occur legally, and the bench asserts on it.
- Simultaneous flush and branch: flush wins and the branch is dropped. Simultaneous flush and rom_ready: the word is discarded (inst_valid=0).

Decomposition:
- defines.v: `RstEnable, `ChipEnable/`ChipDisable, `InstAddrBus, `StallBus, stall encodings (STALL_NONE, STALL_IFWAIT, STALL_ID, STALL_EX), state encodings S_IDLE/S_FETCH.
- Single flat module. No sub-module is needed; the stall-priority encoder and the next-PC mux are separate always blocks inside if_ctrl.

Test Plan:
- Reset 3 cycles, release, rom_ready=1 -> rom_ce=0 for 1 cycle, then pc=0,4,8,12 on consecutive cycles, inst_valid=1, stall=0.
- rom_ready=0 for 2 cycles at pc=8 -> stall=6'b000011 both cycles, pc held 8, inst_valid=0; then ready -> pc=12.
- Branch at pc=0x10 (target 0x100) with rom_ready=1 -> next fetch 0x14 (delay slot), then 0x100. Repeat with ROM wait at 0x14 -> pending held, then 0x100 after ready.
- stallreq_ex for 1 cycle at pc=0x20 -> stall=6'b001111, inst_valid=0, pc held 0x20; stallreq_id -> 6'b000111.
- flush with new_pc=0x80 during a ROM wait with a pending branch -> stall=0, pc=0x80, pending cleared, no fetch of the old target.
- pc forced to 32'hFFFF_FFFC via flush, rom_ready=1 -> next pc=32'h0000_0000. Assert rst mid-wait -> pc=RESET_PC, rom_ce=0 next cycle.
